// File: rtl/cube_scan_sequencer.sv
// Sticker scan sequencer: per slot, NUM_SAMPLES move/settle/sample rounds, a plurality vote, then a restore move.
// Optional SCAN_CONFIDENCE_EN adds a per-slot low_conf flag for votes won without a strict majority.
//
// state   | meaning
// IDLE    | waiting for start
// MOVE    | one-cycle move_req for the current sticker/sample setup step
// WAIT    | waiting for sensor_stable, timeout counting
// SAMPLE  | capture color_sample into the vote buffer
// VOTE    | plurality vote, write winner into state_out
// RESTORE | one-cycle move_req for the restore step
// RWAIT   | waiting for sensor_stable after restore
// DONE    | result held until the next start
module cube_scan_sequencer #(
    parameter int NUM_STICKERS   = 48,
    parameter int COLOR_W        = 3,
    parameter int NUM_SAMPLES    = 4,
    parameter int STABLE_TIMEOUT = 50000000
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                start,
    input  logic                                                sensor_stable,
    input  logic [COLOR_W-1:0]                                  color_sample,
    output logic                                                move_req,
    output logic [$clog2(NUM_STICKERS+1)-1:0]                   move_sticker,
    output logic [((NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1)-1:0] move_sample,
    output logic                                                busy,
    output logic [NUM_STICKERS*COLOR_W-1:0]                     state_out,
    output logic                                                state_valid,
`ifdef SCAN_CONFIDENCE_EN
    output logic                                                scan_error,
    output logic [NUM_STICKERS-1:0]                             low_conf
`else
    output logic                                                scan_error
`endif
);

    localparam int STK_W = $clog2(NUM_STICKERS+1);
    localparam int SMP_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int CNT_W = $clog2(NUM_SAMPLES+1);
    localparam int TO_W  = $clog2(STABLE_TIMEOUT+1);

    localparam logic [STK_W-1:0] LAST_STK    = STK_W'(NUM_STICKERS-1);
    localparam logic [STK_W-1:0] RESTORE_STK = STK_W'(NUM_STICKERS);
    localparam logic [SMP_W-1:0] LAST_SMP    = SMP_W'(NUM_SAMPLES-1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(STABLE_TIMEOUT-1);
    localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(STABLE_TIMEOUT);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MOVE    = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] SAMPLE  = 3'd3;
    localparam logic [2:0] VOTE    = 3'd4;
    localparam logic [2:0] RESTORE = 3'd5;
    localparam logic [2:0] RWAIT   = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    logic [2:0]         state;
    logic [TO_W-1:0]    timeout_cnt;
    logic [COLOR_W-1:0] sample_buf [NUM_SAMPLES];
    logic [CNT_W-1:0]   vote_cnt;
    logic [CNT_W-1:0]   best_cnt;
    logic [COLOR_W-1:0] winner;

    assign move_req = (state == MOVE) || (state == RESTORE);
    assign busy     = (state != IDLE) && (state != DONE);

    // Strict '>' while scanning ascending keeps the tied colour seen first in the buffer.
    always_comb begin
        vote_cnt = '0;
        best_cnt = '0;
        winner   = sample_buf[0];
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            vote_cnt = '0;
            for (int j = 0; j < NUM_SAMPLES; j++) begin
                if (sample_buf[j] == sample_buf[i]) vote_cnt = vote_cnt + CNT_W'(1);
            end
            if (vote_cnt > best_cnt) begin
                best_cnt = vote_cnt;
                winner   = sample_buf[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            move_sticker <= '0;
            move_sample  <= '0;
            state_valid  <= 1'b0;
            scan_error   <= 1'b0;
            state_out    <= '1;
            timeout_cnt  <= '0;
            for (int i = 0; i < NUM_SAMPLES; i++) sample_buf[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= MOVE;
                        move_sticker <= '0;
                        move_sample  <= '0;
                        state_valid  <= 1'b0;
                        scan_error   <= 1'b0;
                        state_out    <= '1;
                        timeout_cnt  <= '0;
                    end
                end
                MOVE: state <= WAIT;
                WAIT, RWAIT: begin
                    if (sensor_stable) begin
                        timeout_cnt <= '0;
                        if (state == WAIT) begin
                            state <= SAMPLE;
                        end else begin
                            state       <= DONE;
                            state_valid <= 1'b1;
                        end
                    end else begin
                        if (timeout_cnt >= TO_LAST) begin
                            state      <= DONE;
                            scan_error <= 1'b1;
                        end
                        if (timeout_cnt != TO_MAX) timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                SAMPLE: begin
                    for (int i = 0; i < NUM_SAMPLES; i++) begin
                        if (move_sample == SMP_W'(i)) sample_buf[i] <= color_sample;
                    end
                    timeout_cnt <= '0;
                    if (move_sample < LAST_SMP) begin
                        move_sample <= move_sample + SMP_W'(1);
                        state       <= MOVE;
                    end else begin
                        state <= VOTE;
                    end
                end
                VOTE: begin
                    for (int k = 0; k < NUM_STICKERS; k++) begin
                        if (move_sticker == STK_W'(k)) state_out[k*COLOR_W +: COLOR_W] <= winner;
                    end
                    move_sample <= '0;
                    if (move_sticker < LAST_STK) begin
                        move_sticker <= move_sticker + STK_W'(1);
                        state        <= MOVE;
                    end else begin
                        move_sticker <= RESTORE_STK;
                        state        <= RESTORE;
                    end
                end
                RESTORE: state <= RWAIT;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCAN_CONFIDENCE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            low_conf <= '0;
        end else if (((state == IDLE) || (state == DONE)) && start) begin
            low_conf <= '0;
        end else if (state == VOTE) begin
            for (int k = 0; k < NUM_STICKERS; k++) begin
                if (move_sticker == STK_W'(k)) low_conf[k] <= ((int'(best_cnt) * 2) <= NUM_SAMPLES);
            end
        end
    end
`endif

endmodule
